// File: rtl/mem_readback.sv
// mem_readback: streams a wrapping address range of a synchronous-read memory over valid/ready.
// Define MEM_READBACK_CHECKSUM_EN to append a mod-2^DATA_W sum of the data words as the final word.
module mem_readback #(
    parameter int ADRS_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADRS_W-1:0] start_adrs,
    input  logic [ADRS_W-1:0] end_adrs,
    output logic              r_enable,
    output logic [ADRS_W-1:0] r_adrs,
    input  logic [DATA_W-1:0] r_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);
`ifdef MEM_READBACK_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, SUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADRS_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADRS_W:0]     remaining_q, remaining_d;
    logic                inflight_q;
    logic [DATA_W-1:0]   buf_q [2];
    logic                hd_q, tl_q;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          outstanding;
    logic                issue, data_valid, data_hs, pop_buf, push, last_data;
    logic [DATA_W-1:0]   data_head;

    // The word returning from memory is visible at the output in the same cycle it arrives,
    // and is only stored if the sink does not take it (or older words are queued ahead of it).
    always_comb begin
        outstanding = cnt_q + {1'b0, inflight_q};
        issue       = (state_q == READ) && (remaining_q != '0) && (outstanding < 2'd2);
        data_valid  = outstanding != 2'd0;
        data_head   = (cnt_q != 2'd0) ? buf_q[hd_q] : (inflight_q ? r_data : '0);
        data_hs     = data_valid & out_ready;
        pop_buf     = data_hs & (cnt_q != 2'd0);
        push        = inflight_q & ~((cnt_q == 2'd0) & out_ready);
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop_buf};
        last_data   = (state_q == DRAIN) && (outstanding == 2'd1);
        r_enable    = issue;
        r_adrs      = issue ? rd_ptr_q : '0;
        busy        = state_q != IDLE;
        cpu_hold    = busy;
        done        = state_q == DONE;
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = READ;
                rd_ptr_d    = start_adrs;
                remaining_d = {1'b0, end_adrs - start_adrs} + (ADRS_W+1)'(1);
            end
            READ: if (issue) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == (ADRS_W+1)'(1)) ? DRAIN : READ;
            end
`ifdef MEM_READBACK_CHECKSUM_EN
            DRAIN:   state_d = (outstanding - {1'b0, data_hs} == 2'd0) ? SUM : DRAIN;
            SUM:     state_d = out_ready ? DONE : SUM;
`else
            DRAIN:   state_d = (outstanding - {1'b0, data_hs} == 2'd0) ? DONE : DRAIN;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            cnt_q       <= 2'd0;
            hd_q        <= 1'b0;
            tl_q        <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            inflight_q  <= issue;
            cnt_q       <= cnt_d;
            if (push) begin
                buf_q[tl_q] <= r_data;
                tl_q        <= ~tl_q;
            end
            if (pop_buf) hd_q <= ~hd_q;
        end
    end

`ifdef MEM_READBACK_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              in_sum;

    always_comb begin
        in_sum    = state_q == SUM;
        sum_d     = (state_q == IDLE && start) ? '0 : (data_hs ? sum_q + data_head : sum_q);
        out_valid = data_valid | in_sum;
        out_data  = in_sum ? sum_q : data_head;
        out_last  = in_sum;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sum_q <= '0;
        else         sum_q <= sum_d;
    end
`else
    always_comb begin
        out_valid = data_valid;
        out_data  = data_head;
        out_last  = last_data;
    end
`endif
endmodule

// File: tb/tb_mem_readback.sv
// tb_mem_readback: table-driven and randomized dumps of a modelled memory, checked against expected word lists.
module tb_mem_readback;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] start_adrs = '0, end_adrs = '0;
    logic          r_enable, out_valid, out_last, busy, cpu_hold, done;
    logic [AW-1:0] r_adrs;
    logic [DW-1:0] r_data = '0, out_data;
    logic [DW-1:0] mem [DEPTH];
    int            errors = 0, checks = 0;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] ea;
        int            mode;
        int            exp_n;
        logic [DW-1:0] exp_last;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;
    always @(posedge clk) if (r_enable) r_data <= mem[r_adrs];

    mem_readback dut (
        .clk(clk), .resetn(resetn), .start(start), .start_adrs(start_adrs), .end_adrs(end_adrs),
        .r_enable(r_enable), .r_adrs(r_adrs), .r_data(r_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .cpu_hold(cpu_hold), .done(done)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[3 - ((cyc - 1) % 4)];
        return ($urandom % 3) != 0;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_r_enable"}, 32'(r_enable), 0);
        check({tag, "_r_adrs"}, 32'(r_adrs), 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // Runs one dump; the expected word list is built from the address range and memory contents.
    task automatic run_dump(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int mode,
                            output int n_data, output logic [DW-1:0] last_data, output logic [DW-1:0] fin_word);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] sum, prev_data;
        logic [AW-1:0] span;
        logic          prev_stall, fin;
        int            n, total, cyc, issued, accepted, hs_cyc, done_cyc, done_cnt;
        span = ea - sa;
        n = int'(span) + 1;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[(int'(sa) + i) % DEPTH]);
            sum += mem[(int'(sa) + i) % DEPTH];
        end
`ifdef MEM_READBACK_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        total = exp_q.size();
        issued = 0; accepted = 0; hs_cyc = -1; done_cyc = -1; done_cnt = 0;
        prev_stall = 1'b0; prev_data = '0; fin = 1'b0; last_data = '0; fin_word = '0;
        @(posedge clk); #1;
        start = 1'b1; start_adrs = sa; end_adrs = ea; out_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        while (!fin && cyc < 6000) begin
            start = (mode == 2 && cyc == 3);
            start_adrs = AW'($urandom);
            end_adrs = AW'($urandom);
            out_ready = ready_for(mode, cyc);
            @(negedge clk);
            if (cyc == 1) check("busy_cycle1", 32'(busy), 1);
            if (cpu_hold !== busy) check("cpu_hold_eq_busy", 32'(cpu_hold), 32'(busy));
            if (r_enable) begin
                check("r_en_with_space", 32'((issued - accepted) < 2), 1);
                check("r_en_within_range", 32'(issued < n), 1);
                check("r_adrs", 32'(r_adrs), (int'(sa) + issued) % DEPTH);
                issued++;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (accepted < total) begin
                    check("word", out_data, exp_q[accepted]);
                    check("last_flag", 32'(out_last), 32'(accepted == total - 1));
                end else check("extra_word", 32'(accepted), 32'(total));
                if (accepted == n - 1) last_data = out_data;
                fin_word = out_data;
                accepted++;
                hs_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; out_ready = 1'b0;
        check("done_seen", 32'(done_cnt), 1);
        check("words_accepted", 32'(accepted), 32'(total));
        check("done_after_last", 32'(done_cyc), 32'(hs_cyc + 1));
        if (mode == 0) check("last_hs_cycle", 32'(hs_cyc), 32'(total + 1));
        @(negedge clk);
        check("busy_low_after", 32'(busy), 0);
        check("done_single_pulse", 32'(done), 0);
        n_data = accepted;
`ifdef MEM_READBACK_CHECKSUM_EN
        n_data = accepted - 1;
`endif
    endtask

    initial begin
        int            nd, hs;
        logic [DW-1:0] ld, fw;
        logic [AW-1:0] sa;
        int            len;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h0000000d;
        mem[1] = 32'h0000000f;
        mem[2] = 32'h000000c3;
        mem[11'h0ff] = 32'hffffffff;
        vecs[0] = '{sa: 11'h000, ea: 11'h002, mode: 0, exp_n: 3,    exp_last: 32'h000000c3};
        vecs[1] = '{sa: 11'h000, ea: 11'h002, mode: 1, exp_n: 3,    exp_last: 32'h000000c3};
        vecs[2] = '{sa: 11'h7fe, ea: 11'h001, mode: 0, exp_n: 4,    exp_last: 32'h0000000f};
        vecs[3] = '{sa: 11'h0ff, ea: 11'h0ff, mode: 0, exp_n: 1,    exp_last: 32'hffffffff};
        vecs[4] = '{sa: 11'h003, ea: 11'h002, mode: 0, exp_n: 2048, exp_last: 32'h000000c3};
        vecs[5] = '{sa: 11'h7fe, ea: 11'h002, mode: 2, exp_n: 5,    exp_last: 32'h000000c3};

        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        foreach (vecs[i]) begin
            run_dump(vecs[i].sa, vecs[i].ea, vecs[i].mode, nd, ld, fw);
            check($sformatf("vec%0d_count", i), 32'(nd), 32'(vecs[i].exp_n));
            check($sformatf("vec%0d_last_data", i), ld, vecs[i].exp_last);
`ifdef MEM_READBACK_CHECKSUM_EN
            if (i == 0) check("checksum_0_2", fw, 32'h000000df);
`else
            if (i == 0) check("final_word_0_2", fw, 32'h000000c3);
`endif
        end

        // Reset in the middle of a 10-word dump: everything clears and no done pulse follows.
        @(posedge clk); #1;
        start = 1'b1; start_adrs = 11'h020; end_adrs = 11'h029;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 50 && hs < 2; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
        end
        check("mid_reset_two_words", 32'(hs), 2);
        resetn = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_reset_no_done", 32'(done), 0);
            check("mid_reset_idle", 32'(busy | out_valid | r_enable), 0);
        end
        @(posedge clk); #1 resetn = 1'b1; out_ready = 1'b0;
        run_dump(11'h000, 11'h002, 0, nd, ld, fw);
        check("post_reset_count", 32'(nd), 3);
        check("post_reset_last", ld, 32'h000000c3);

        for (int t = 0; t < 8; t++) begin
            sa = AW'($urandom);
            len = $urandom_range(1, 40);
            run_dump(sa, sa + AW'(len - 1), t % 3, nd, ld, fw);
            check($sformatf("rand%0d_count", t), 32'(nd), 32'(len));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_readback.md
# mem_readback

Reads a contiguous range of the CPU's 2048-word, 32-bit memory through its synchronous read port and streams the words out over a valid/ready interface. It is the read-side counterpart of the `w_enable`/`w_adrs`/`w_instruction` programming path. It is used after a run, with `cpu_en` low, to dump results such as the multiply product at address 2. It asserts `cpu_hold` while active so the surrounding logic keeps the CPU stopped.

## Interface
- `ADRS_W`, 11, memory address width; memory depth is 2^ADRS_W.
- `DATA_W`, 32, memory word width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; ignored unless idle.
- `start_adrs`  in  ADRS_W  first address, sampled on an accepted `start`.
- `end_adrs`  in  ADRS_W  last address (inclusive), sampled on an accepted `start`.
- `r_enable`  out  1  memory read strobe.
- `r_adrs`  out  ADRS_W  memory read address.
- `r_data`  in  DATA_W  memory read data, valid exactly 1 cycle after `r_enable`.
- `out_data`  out  DATA_W  streamed word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the word when `out_valid & out_ready`.
- `out_last`  out  1  marks the final word of the dump.
- `busy`  out  1  a dump is in progress.
- `cpu_hold`  out  1  equals `busy`; the CPU must stay disabled.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE (plus SUM when the checksum option is compiled in).
- IDLE → READ on `start`.
  - Latches `rd_ptr = start_adrs`.
  - Latches `remaining = ((end_adrs - start_adrs) mod 2^ADRS_W) + 1`, held in ADRS_W+1 bits.
  - `end_adrs < start_adrs` wraps through address 0. `end_adrs == start_adrs` reads 1 word. The full range is reached by `end_adrs = start_adrs - 1`, which reads 2048 words.
- READ: issues a read when `remaining != 0` and `(buf_count + inflight) < 2`.
  - Drives `r_enable = 1` and `r_adrs = rd_ptr`.
  - Then `rd_ptr` increments mod 2^ADRS_W and `remaining` decrements.
  - `inflight` is 1 in the cycle after a read is issued. `r_data` is then written into a 2-entry FIFO output buffer.
  - The FSM moves to DRAIN when the last read has been issued.
- DRAIN: waits until `inflight == 0` and the buffer is empty, then goes to DONE, or to SUM when the checksum option is compiled in.
- DONE: `done = 1` for one cycle, then IDLE.
- `out_last` is high on the final streamed word only.
- `out_data`/`out_valid` come from the buffer head. A word stays stable while `out_valid & !out_ready`.
- `start` while busy has no effect and does not re-sample the addresses.
- `r_enable` is never asserted outside READ.

## Timing
- Reset values:
  - All outputs are 0: `r_enable`, `r_adrs`, `out_data`, `out_valid`, `out_last`, `busy`, `cpu_hold`, `done`.
  - Internal state: FSM = IDLE, buffer empty, `inflight = 0`.
- Cycle timeline:
  - `start` accepted at edge 0.
  - `busy` high and first `r_enable` in cycle 1.
  - First word captured at edge 2; `out_valid` high in cycle 2.
- With `out_ready` held high: one word per cycle. An N-word dump finishes its last handshake in cycle N+1. `done` is high in cycle N+2 and `busy` is low from cycle N+3.
- Backpressure: a read is issued only when there is space, so the buffer never overflows and no word is lost or duplicated.
- Reset asserted mid-dump: immediate return to reset values. Partial data is discarded and no `done` pulse is produced.

## Configuration
- `MEM_READBACK_CHECKSUM_EN` defined:
  - After the data words, SUM emits one extra word: the mod-2^32 sum of all streamed data words.
  - `out_last` moves to the checksum word; the data words no longer carry it.
  - `done` follows the checksum handshake.
- Undefined: there is no SUM state, no accumulator and no extra word.

## Test plan
- Preload memory [0]=0x0000000d, [1]=0x0000000f, [2]=0x000000c3. Dump 0..2 with `out_ready`=1 → words d, f, c3 in cycles 2-4, `out_last` on c3, `done` in cycle 5.
- Dump 0..2 while `out_ready` toggles 1,0,0,1,... → same three words in order, each held stable while stalled, and `r_enable` never asserted with 2 words outstanding.
- Dump 0x7fe..0x001 → addresses 7fe, 7ff, 000, 001 read in that order; 4 words.
- Dump start=end=0x0ff with [0x0ff]=0xffffffff → single word 0xffffffff with `out_last`=1.
- Assert `resetn`=0 after the 2nd word of a 10-word dump → all outputs 0 next cycle and no `done`; a new `start` afterwards dumps cleanly.
- With `MEM_READBACK_CHECKSUM_EN` defined, dump 0..2 → 4 words ending with 0x000000df, which carries `out_last`.
